pixel_scaler: RTL
=================

# pixel_scaler

Parametrised, registered successor to the combinational coordinate scaler: it maps raw video-timing counts (hcount/vcount) onto source-frame addresses using independent runtime integer scale factors per axis (1..MAX_SCALE, not limited to powers of two). Scale factors are sampled only at frame start, so a mid-frame change never tears the image. It sits between the video signal generator and the frame-buffer read port, and drives the read address and in-bounds qualifier.

## Interface
Parameters:
- H_WIDTH, 11, width of hcount_in and scaled_hcount_out
- V_WIDTH, 10, width of vcount_in and scaled_vcount_out
- SRC_W, 240, source frame width in pixels
- SRC_H, 320, source frame height in lines
- MAX_SCALE, 4, largest legal scale factor per axis
- SCALE_W, 3, width of the scale inputs (must hold MAX_SCALE)

Ports:
- clk_in  input  1  pixel clock; single clock domain
- rst_in  input  1  reset, asynchronous, active-high
- scale_h_in  input  SCALE_W  requested horizontal scale factor
- scale_v_in  input  SCALE_W  requested vertical scale factor
- hcount_in  input  H_WIDTH  raw horizontal count; increments by 1 per clock, returns to 0 each line
- vcount_in  input  V_WIDTH  raw vertical count; changes only on the cycle hcount_in==0
- scaled_hcount_out  output  H_WIDTH  hcount_in / active_sx, saturating at SRC_W
- scaled_vcount_out  output  V_WIDTH  vcount_in / active_sy, saturating at SRC_H
- valid_addr_out  output  1  scaled coordinates lie inside SRC_W x SRC_H and the block is locked
- active_scale_h_out  output  SCALE_W  horizontal factor currently in use
- active_scale_v_out  output  SCALE_W  vertical factor currently in use

## Operation
- Sanitise: a requested factor of 0 or > MAX_SCALE is treated as 1.
- Frame start is the cycle with hcount_in==0 and vcount_in==0. On it: active_sx/active_sy <= sanitised inputs; locked <= 1. Requests on any other cycle are ignored.
- Division uses counters, not a divider. State per axis: sub-counter (0..factor-1) and scaled counter.
- Horizontal, every cycle:
  - hcount_in==0: sub_h <= 0, sh <= 0.
  - Otherwise, if sub_h == active_sx-1: sub_h <= 0 and sh <= sh+1 (held once sh == SRC_W).
  - Otherwise: sub_h <= sub_h+1.
- Vertical, only on cycles with hcount_in==0:
  - vcount_in==0: sub_v <= 0, sv <= 0.
  - Otherwise, advance sub_v/sv by the same rule with active_sy, holding sv once it reaches SRC_H.
  - sv holds on all other cycles.
- Outputs are the sh/sv registers. valid_addr_out is registered from locked && sh_next < SRC_W && sv_next < SRC_H.
- Non-power-of-two factors (e.g. 3) are exact: scaled_hcount_out == floor(hcount/3).
- The new factors are applied from the cycle after frame start (hcount_in==1 onward). The frame-start cycle itself always yields 0/0.

## Timing
- Latency: 1 clock. Outputs at cycle t+1 correspond to hcount_in/vcount_in at cycle t.
- Reset (asynchronous, immediate):
  - Outputs: scaled_hcount_out=0, scaled_vcount_out=0, valid_addr_out=0, active_scale_h_out=1, active_scale_v_out=1.
  - Internal state: sub counters 0, locked=0.
- Reset mid-frame: valid_addr_out stays 0 until the first frame start after reset release. The scaled counters still run but are not trusted until then.
- Saturation: scaled counters never wrap. Beyond the source edge they hold at SRC_W/SRC_H with valid_addr_out=0, through blanking, until the next line or frame start.
- Simultaneous events: a frame start in the same cycle as a scale-input change latches the new value. A line start always overrides horizontal counting.
- Scale-input changes between frame starts have no effect on any output.

## Test plan
- Reset then scale 1/1: hcount 0..239, vcount 0 after a frame start -> scaled_hcount_out = hcount delayed 1 cycle. valid=1 through hcount 239, 0 from 240.
- Scale 3/2, frame start then a line: hcount 5 -> scaled_h 1; hcount 719 -> 239 with valid=1; hcount 720 -> 240 with valid=0. vcount 7 -> scaled_v 3.
- Scale 4/1 requested mid-frame while active is 2/2 -> outputs keep dividing by 2 until the next frame start; active_scale_h_out becomes 4 one cycle after it.
- Illegal request scale_h_in=0 or 7 with MAX_SCALE=4 -> active_scale_h_out=1 after frame start, scaled_h == hcount.
- Assert rst_in at hcount 300, vcount 100 -> all outputs reset immediately. After release, valid stays 0 through the rest of the frame and returns at the next (0,0).
- vcount 639 at scale_v 2 -> scaled_v 319 valid. vcount 640 -> scaled_v 320, valid=0, held to end of frame.

Source files
------------

// File: rtl/pixel_scaler.sv
// Registered video coordinate scaler: maps raw hcount/vcount onto source-frame
// addresses with per-axis integer factors that are latched only at frame start.
module pixel_scaler #(
  parameter int H_WIDTH   = 11,
  parameter int V_WIDTH   = 10,
  parameter int SRC_W     = 240,
  parameter int SRC_H     = 320,
  parameter int MAX_SCALE = 4,
  parameter int SCALE_W   = 3
) (
  input  logic               clk_in,
  input  logic               rst_in,
  input  logic [SCALE_W-1:0] scale_h_in,
  input  logic [SCALE_W-1:0] scale_v_in,
  input  logic [H_WIDTH-1:0] hcount_in,
  input  logic [V_WIDTH-1:0] vcount_in,
  output logic [H_WIDTH-1:0] scaled_hcount_out,
  output logic [V_WIDTH-1:0] scaled_vcount_out,
  output logic               valid_addr_out,
  output logic [SCALE_W-1:0] active_scale_h_out,
  output logic [SCALE_W-1:0] active_scale_v_out
);

  localparam int SUB_W = (MAX_SCALE > 1) ? $clog2(MAX_SCALE) : 1;

  logic [SCALE_W-1:0] active_sx_reg, active_sx_next;
  logic [SCALE_W-1:0] active_sy_reg, active_sy_next;
  logic               locked_reg, locked_next;
  logic [SUB_W-1:0]   sub_h_reg, sub_h_next;
  logic [SUB_W-1:0]   sub_v_reg, sub_v_next;
  logic [H_WIDTH-1:0] sh_reg, sh_next;
  logic [V_WIDTH-1:0] sv_reg, sv_next;
  logic               valid_reg, valid_next;

  logic line_start;
  logic frame_start;
  logic h_wrap;
  logic v_wrap;

  // Out-of-range requests fall back to unity scaling.
  function automatic logic [SCALE_W-1:0] sanitise(input logic [SCALE_W-1:0] req);
    if (req == '0 || req > SCALE_W'(MAX_SCALE)) begin
      return SCALE_W'(1);
    end
    return req;
  endfunction

  assign line_start  = (hcount_in == '0);
  assign frame_start = line_start && (vcount_in == '0);
  assign h_wrap      = (SCALE_W'(sub_h_reg) == active_sx_reg - SCALE_W'(1));
  assign v_wrap      = (SCALE_W'(sub_v_reg) == active_sy_reg - SCALE_W'(1));

  always_comb begin
    active_sx_next = active_sx_reg;
    active_sy_next = active_sy_reg;
    locked_next    = locked_reg;
    sub_h_next     = sub_h_reg;
    sub_v_next     = sub_v_reg;
    sh_next        = sh_reg;
    sv_next        = sv_reg;

    if (frame_start) begin
      active_sx_next = sanitise(scale_h_in);
      active_sy_next = sanitise(scale_v_in);
      locked_next    = 1'b1;
    end

    // Sub-counters replace a divider: the scaled count steps once per factor.
    if (line_start) begin
      sub_h_next = '0;
      sh_next    = '0;
    end else if (h_wrap) begin
      sub_h_next = '0;
      if (sh_reg != H_WIDTH'(SRC_W)) begin
        sh_next = sh_reg + H_WIDTH'(1);
      end
    end else begin
      sub_h_next = sub_h_reg + SUB_W'(1);
    end

    if (line_start) begin
      if (vcount_in == '0) begin
        sub_v_next = '0;
        sv_next    = '0;
      end else if (v_wrap) begin
        sub_v_next = '0;
        if (sv_reg != V_WIDTH'(SRC_H)) begin
          sv_next = sv_reg + V_WIDTH'(1);
        end
      end else begin
        sub_v_next = sub_v_reg + SUB_W'(1);
      end
    end

    valid_next = locked_next && (sh_next < H_WIDTH'(SRC_W)) && (sv_next < V_WIDTH'(SRC_H));
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      active_sx_reg <= SCALE_W'(1);
      active_sy_reg <= SCALE_W'(1);
      locked_reg    <= 1'b0;
      sub_h_reg     <= '0;
      sub_v_reg     <= '0;
      sh_reg        <= '0;
      sv_reg        <= '0;
      valid_reg     <= 1'b0;
    end else begin
      active_sx_reg <= active_sx_next;
      active_sy_reg <= active_sy_next;
      locked_reg    <= locked_next;
      sub_h_reg     <= sub_h_next;
      sub_v_reg     <= sub_v_next;
      sh_reg        <= sh_next;
      sv_reg        <= sv_next;
      valid_reg     <= valid_next;
    end
  end

  assign scaled_hcount_out  = sh_reg;
  assign scaled_vcount_out  = sv_reg;
  assign valid_addr_out     = valid_reg;
  assign active_scale_h_out = active_sx_reg;
  assign active_scale_v_out = active_sy_reg;

endmodule
